// File: rtl/rsa_pkg.sv
// Shared RSA datapath defaults and the exponentiation sequencer state encoding,
// used by mont_exp and by the rsa wrapper that owns the montgomery multiplier.
package rsa_pkg;

    localparam int unsigned RSA_WIDTH     = 1024;
    localparam int unsigned RSA_EXP_WIDTH = 1024;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TO_MONT   = 3'd1,
        ST_SQUARE    = 3'd2,
        ST_MULT      = 3'd3,
        ST_FROM_MONT = 3'd4,
        ST_DONE      = 3'd5
    } mexp_state_e;

endpackage

// File: rtl/mont_exp.sv
// Left-to-right square-and-multiply modular exponentiation sequencer driving an
// external montgomery multiplier through the mm_* request/reply ports.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start; operands latched on acceptance
// TO_MONT   | Xt = MM(x, R^2 mod n); A preset to R mod n
// SQUARE    | A = MM(A, A) for exponent bit idx
// MULT      | A = MM(A, Xt) when exponent bit idx is set
// FROM_MONT | result = MM(A, 1), leaving the montgomery domain
// DONE      | one-cycle done pulse, then back to IDLE
module mont_exp
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH     = RSA_WIDTH,
    parameter int unsigned EXP_WIDTH = RSA_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [EXP_WIDTH-1:0] e,
    input  logic [31:0]          e_len,
    input  logic [WIDTH-1:0]     n,
    input  logic [WIDTH-1:0]     r_n,
    input  logic [WIDTH-1:0]     r2n,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH:0]       mm_result,
    input  logic                 mm_done,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result
);

    localparam int unsigned LEN_W = $clog2(EXP_WIDTH + 1);
    localparam int unsigned IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    mexp_state_e          state_q, state_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0]     n_q, n_d;
    logic [WIDTH-1:0]     rn_q, rn_d;
    logic [WIDTH-1:0]     r2n_q, r2n_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]     xt_q, xt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 issue_q, issue_d;
    logic                 pend_q, pend_d;

    logic                 mm_ack;
    logic [WIDTH-1:0]     mm_prod;
    logic                 unused_mm_msb;

    // The multiplier may return a value up to 2n; only the low WIDTH bits are kept.
    assign mm_prod       = mm_result[WIDTH-1:0];
    assign unused_mm_msb = mm_result[WIDTH];

    // A reply only counts while a product is outstanding, so stray or stale
    // mm_done pulses (e.g. from a run aborted by reset) fall on the floor.
    assign mm_ack = mm_done && pend_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            rn_q     <= '0;
            r2n_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            xt_q     <= '0;
            a_q      <= '0;
            result_q <= '0;
            issue_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            e_q      <= e_d;
            n_q      <= n_d;
            rn_q     <= rn_d;
            r2n_q    <= r2n_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            xt_q     <= xt_d;
            a_q      <= a_d;
            result_q <= result_d;
            issue_q  <= issue_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        e_d      = e_q;
        n_d      = n_q;
        rn_d     = rn_q;
        r2n_d    = r2n_q;
        len_d    = len_q;
        idx_d    = idx_q;
        xt_d     = xt_q;
        a_d      = a_q;
        result_d = result_q;
        issue_d  = 1'b0;
        pend_d   = pend_q;

        if (mm_ack) begin
            pend_d = 1'b0;
        end else if (issue_q) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d   = x;
                    e_d   = e;
                    n_d   = n;
                    rn_d  = r_n;
                    r2n_d = r2n;
                    if (e_len > EXP_WIDTH) begin
                        len_d = LEN_W'(EXP_WIDTH);
                    end else begin
                        len_d = LEN_W'(e_len);
                    end
                    state_d = ST_TO_MONT;
                    issue_d = 1'b1;
                end
            end

            ST_TO_MONT: begin
                if (mm_ack) begin
                    xt_d    = mm_prod;
                    a_d     = rn_q;
                    idx_d   = IDX_W'(len_q - LEN_W'(1));
                    state_d = (len_q == '0) ? ST_FROM_MONT : ST_SQUARE;
                    issue_d = 1'b1;
                end
            end

            ST_SQUARE: begin
                if (mm_ack) begin
                    a_d     = mm_prod;
                    issue_d = 1'b1;
                    if (e_q[idx_q]) begin
                        state_d = ST_MULT;
                    end else if (idx_q == '0) begin
                        state_d = ST_FROM_MONT;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end

            ST_MULT: begin
                if (mm_ack) begin
                    a_d     = mm_prod;
                    issue_d = 1'b1;
                    if (idx_q == '0) begin
                        state_d = ST_FROM_MONT;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = ST_SQUARE;
                    end
                end
            end

            ST_FROM_MONT: begin
                if (mm_ack) begin
                    result_d = mm_prod;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operands come only from registers that change on an accepted reply,
    // so they stay stable for the whole time a product is outstanding.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state_q)
            ST_TO_MONT: begin
                mm_a = x_q;
                mm_b = r2n_q;
            end
            ST_SQUARE: begin
                mm_a = a_q;
                mm_b = a_q;
            end
            ST_MULT: begin
                mm_a = a_q;
                mm_b = xt_q;
            end
            ST_FROM_MONT: begin
                mm_a = a_q;
                mm_b = WIDTH'(1);
            end
            default: begin
                mm_a = '0;
                mm_b = '0;
            end
        endcase
    end

    assign mm_start = issue_q;
    assign mm_m     = n_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;

endmodule

// File: tb/tb_mont_exp.sv
// Self-checking bench for mont_exp with WIDTH=EXP_WIDTH=8, n=197 and a
// behavioural 5-cycle montgomery multiplier responder.
module tb_mont_exp;

    localparam int W   = 8;
    localparam int EW  = 8;
    localparam int N   = 197;
    localparam int RN  = 59;
    localparam int R2N = 132;
    localparam int LAT = 5;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          start  = 1'b0;
    logic [W-1:0]  x      = '0;
    logic [EW-1:0] e      = '0;
    logic [31:0]   e_len  = '0;
    logic [W-1:0]  n      = W'(N);
    logic [W-1:0]  r_n    = W'(RN);
    logic [W-1:0]  r2n    = W'(R2N);
    logic          mm_start;
    logic [W-1:0]  mm_a, mm_b, mm_m;
    logic [W:0]    mm_result;
    logic          mm_done;
    logic          busy, done;
    logic [W-1:0]  result;

    int n_cmp = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int stab_err = 0;
    int idle_start_err = 0;
    int overlap_err = 0;
    int stray_seq = 0;
    int s0, s1, cyc;

    mont_exp #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .x         (x),
        .e         (e),
        .e_len     (e_len),
        .n         (n),
        .r_n       (r_n),
        .r2n       (r2n),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_m      (mm_m),
        .mm_result (mm_result),
        .mm_done   (mm_done),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Multiplier responder: a*b*R^-1 mod n, reply LAT cycles after mm_start.
    initial begin : mm_model
        int cnt, rinv, val, stray_seen;
        logic [W-1:0] cap_a, cap_b;
        cnt = 0; rinv = 0; val = 0; stray_seen = 0;
        cap_a = '0; cap_b = '0;
        mm_done = 1'b0;
        mm_result = '0;
        for (int i = 1; i < N; i++) if (((256 * i) % N) == 1) rinv = i;
        forever begin
            @(posedge clk); #1;
            mm_done = 1'b0;
            if (done === 1'b1) done_cnt++;
            if (cnt > 0) begin
                if (busy === 1'b1 && (mm_a !== cap_a || mm_b !== cap_b || mm_m !== W'(N)))
                    stab_err++;
                cnt--;
                if (cnt == 0) begin
                    mm_done = 1'b1;
                    mm_result = (W+1)'(val);
                end
            end else if (stray_seen != stray_seq) begin
                stray_seen = stray_seq;
                mm_done = 1'b1;
                mm_result = 9'h0AB;
            end
            if (mm_start === 1'b1) begin
                start_cnt++;
                if (busy !== 1'b1) idle_start_err++;
                if (cnt != 0) overlap_err++;
                cap_a = mm_a;
                cap_b = mm_b;
                val = (int'(mm_a) * int'(mm_b) * rinv) % N;
                cnt = LAT;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: x^e mod n by repeated multiplication over the effective exponent.
    function automatic int ref_modexp(input int xv, input int ev, input int len);
        longint r;
        int em;
        em = (len >= 31) ? ev : (ev & ((1 << len) - 1));
        r = 1;
        for (int k = 0; k < em; k++) r = (r * xv) % N;
        return int'(r);
    endfunction

    task automatic run_exp(input int xv, input int ev, input int lenv, input int hold,
                           input string tag);
        int exp_r, exp_p, L, pc, st0, dn0, c;
        L = (lenv > EW) ? EW : lenv;
        exp_r = ref_modexp(xv, ev, L);
        pc = 0;
        for (int i = 0; i < L; i++) pc += (ev >> i) & 1;
        exp_p = 2 + L + pc;
        st0 = start_cnt;
        dn0 = done_cnt;
        x = W'(xv);
        e = EW'(ev);
        e_len = 32'(lenv);
        start = 1'b1;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        c = 0;
        while (done !== 1'b1 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp_r));
        @(negedge clk);
        check({tag, "_done_off"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_hold"}, 32'(result), 32'(exp_r));
        check({tag, "_pulses"}, 32'(start_cnt - st0), 32'(exp_p));
        check({tag, "_done_cnt"}, 32'(done_cnt - dn0), 32'd1);
    endtask

    initial begin : main
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mm_start", 32'(mm_start), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_exp(5, 3, 2, 1, "s1");
        run_exp(5, 11, 4, 1, "s2");
        run_exp(77, 165, 0, 1, "s3");
        run_exp(5, 3, 40, 1, "s4");

        // Abort a run during its first square, then restart.
        s0 = start_cnt;
        x = 8'd5; e = 8'd3; e_len = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (start_cnt < s0 + 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("s5_reach_square", 32'(start_cnt - s0), 32'd2);
        resetn = 1'b0;
        @(negedge clk);
        check("s5_rst_busy", 32'(busy), 32'd0);
        check("s5_rst_done", 32'(done), 32'd0);
        check("s5_rst_mm_start", 32'(mm_start), 32'd0);
        check("s5_rst_result", 32'(result), 32'd0);
        resetn = 1'b1;
        s1 = start_cnt;
        repeat (12) @(negedge clk);
        check("s5_no_start", 32'(start_cnt - s1), 32'd0);
        check("s5_stale_ignored", 32'(busy), 32'd0);
        run_exp(5, 3, 2, 1, "s5");

        // Stray reply while idle, then a start held for three cycles.
        s1 = start_cnt;
        stray_seq++;
        repeat (4) @(negedge clk);
        check("s6_stray_busy", 32'(busy), 32'd0);
        check("s6_stray_result", 32'(result), 32'd125);
        check("s6_stray_start", 32'(start_cnt - s1), 32'd0);
        run_exp(5, 11, 4, 3, "s6");

        for (int i = 0; i < 8; i++) begin
            run_exp(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 10)), int'($urandom_range(1, 3)),
                    $sformatf("rnd%0d", i));
        end

        check("operand_stability", 32'(stab_err), 32'd0);
        check("idle_mm_start", 32'(idle_start_err), 32'd0);
        check("overlapping_mm_start", 32'(overlap_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
